// File: rtl/memoria_dupla_limpavel_if.sv
// Bus bundle for memoria_dupla_limpavel: write port, dual read port,
// clear request and status outputs. Clock and reset stay outside.
interface memoria_dupla_limpavel_if #(
    parameter int unsigned NBITS_DADOS = 4,
    parameter int unsigned NBITS_END   = 2
);
    logic                   we;
    logic [NBITS_END-1:0]   waddr;
    logic [NBITS_DADOS-1:0] wdata;
    logic                   re;
    logic [NBITS_END-1:0]   raddr_a;
    logic [NBITS_END-1:0]   raddr_b;
    logic                   clr;
    logic [NBITS_DADOS-1:0] rdata_a;
    logic [NBITS_DADOS-1:0] rdata_b;
    logic                   rvalid;
    logic                   busy;
    logic                   clr_done;

    modport master (
        output we, waddr, wdata, re, raddr_a, raddr_b, clr,
        input  rdata_a, rdata_b, rvalid, busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, re, raddr_a, raddr_b, clr,
        output rdata_a, rdata_b, rvalid, busy, clr_done
    );
endinterface

// File: rtl/memoria_dupla_limpavel.sv
// Synchronous RAM with one write port, two registered read ports sharing
// one read enable, and a clear engine that sweeps every word to CLR_VALUE
// after reset release and whenever a clear is requested while idle.
module memoria_dupla_limpavel #(
    parameter int unsigned            NBITS_DADOS = 4,
    parameter int unsigned            NBITS_END   = 2,
    parameter logic [NBITS_DADOS-1:0] CLR_VALUE   = '0
) (
    input  logic                     clk_2,
    input  logic                     reset_n,
    memoria_dupla_limpavel_if.slave  bus
);
    localparam int unsigned          DEPTH = 2**NBITS_END;
    localparam logic [NBITS_END-1:0] LAST  = NBITS_END'(DEPTH - 1);

    typedef enum logic {
        OCIOSO,
        LIMPA
    } estado_t;

    estado_t                r_estado;
    logic [NBITS_END-1:0]   r_ptr;
    logic [NBITS_DADOS-1:0] r_mem [DEPTH];
    logic [NBITS_DADOS-1:0] r_rdata_a;
    logic [NBITS_DADOS-1:0] r_rdata_b;
    logic                   r_rvalid;
    logic                   r_busy;
    logic                   r_clr_done;

    logic                   w_mem_we;
    logic [NBITS_END-1:0]   w_mem_addr;
    logic [NBITS_DADOS-1:0] w_mem_data;

    // Single write port shared by the sweep and the user; held off during
    // reset so the array is only initialised by the sweep that follows.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.waddr;
        w_mem_data = bus.wdata;
        if (r_estado == LIMPA) begin
            w_mem_we   = reset_n;
            w_mem_addr = r_ptr;
            w_mem_data = CLR_VALUE;
        end else if (!bus.clr && bus.we) begin
            w_mem_we   = reset_n;
        end
    end

    // Storage array; no reset, contents come from the clear sweep.
    always_ff @(posedge clk_2) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Control FSM with registered read data and status; reads sample the
    // array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_estado   <= LIMPA;
            r_ptr      <= '0;
            r_busy     <= 1'b1;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_rvalid   <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            case (r_estado)
                LIMPA: begin
                    r_rvalid <= 1'b0;
                    r_ptr    <= r_ptr + 1'b1;
                    if (r_ptr == LAST) begin
                        r_estado   <= OCIOSO;
                        r_busy     <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_clr_done <= 1'b0;
                    end
                end
                default: begin
                    r_clr_done <= 1'b0;
                    r_rvalid   <= bus.re;
                    if (bus.re) begin
                        r_rdata_a <= r_mem[bus.raddr_a];
                        r_rdata_b <= r_mem[bus.raddr_b];
                    end
                    if (bus.clr) begin
                        r_estado <= LIMPA;
                        r_ptr    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.rdata_a  = r_rdata_a;
    assign bus.rdata_b  = r_rdata_b;
    assign bus.rvalid   = r_rvalid;
    assign bus.busy     = r_busy;
    assign bus.clr_done = r_clr_done;
endmodule
